// File: rtl/screen_line_fetch.sv
// Line fetcher for the NTSC screen unit: fills one bank of a ping-pong line
// buffer from memory while the other bank serves unpacked 8-bit pixels.
module screen_line_fetch #(
    parameter int DW         = 16,
    parameter int AW         = 19,
    parameter int LINE_WORDS = 64,
    parameter int MAX_OUT    = 4,
    parameter int LW         = $clog2(LINE_WORDS + 1),
    parameter int CW         = $clog2(LINE_WORDS * DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_start,
    input  logic [AW-1:0] line_base,
    input  logic [LW-1:0] line_len,
    input  logic [1:0]    bpp_mode,
    output logic          mem_addr_vld,
    input  logic          mem_addr_gnt,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_dat_vld,
    output logic          mem_dat_gnt,
    input  logic [DW-1:0] mem_dat,
    input  logic          rd_en,
    input  logic [CW-1:0] rd_col,
    output logic [7:0]    pix_val,
    output logic          fetch_busy,
    output logic          line_done,
    output logic          underrun
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int BW = $clog2(2 * LINE_WORDS);
    localparam int XW = CW + 3;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state, state_nxt;
    logic          fill_bank;
    logic          disp_bank;
    logic [AW-1:0] fill_base;
    logic [LW-1:0] req_cnt;
    logic [LW-1:0] rsp_cnt;
    logic [OW-1:0] outstanding;
    logic [LW-1:0] bank_len [2];
    logic [LW-1:0] fill_len;
    logic [LW-1:0] len_clamped;
    logic [1:0]    disp_bpp;
    logic [DW-1:0] line_mem [2*LINE_WORDS];

    logic          addr_xfer, dat_xfer, wr_en, last_word;
    logic          swap, set_underrun;
    logic [BW-1:0] wr_idx;

    logic [XW-1:0] rd_bit_p0;
    logic [XW-1:0] rd_word_p0;
    logic [XW-1:0] rd_sh_p0;
    logic          rd_hit_p0;
    logic [BW-1:0] rd_idx_p0;
    logic [7:0]    rd_raw_p0;

    // Replicate a narrow pixel field across the 8-bit output.
    function automatic logic [7:0] expand_pix(input logic [7:0] raw, input logic [1:0] mode);
        case (mode)
            2'd0:    return {8{raw[0]}};
            2'd1:    return {4{raw[1:0]}};
            2'd2:    return {2{raw[3:0]}};
            default: return raw;
        endcase
    endfunction

    assign disp_bank   = ~fill_bank;
    assign fill_len    = bank_len[fill_bank];
    assign len_clamped = (line_len > LW'(LINE_WORDS)) ? LW'(LINE_WORDS) : line_len;
    assign mem_addr    = fill_base + AW'(req_cnt);
    assign mem_dat_gnt = (outstanding != '0);
    assign addr_xfer   = mem_addr_vld & mem_addr_gnt;
    assign dat_xfer    = mem_dat_vld & mem_dat_gnt;
    assign wr_en       = (state == REQ) && dat_xfer;
    assign last_word   = wr_en && ((rsp_cnt + LW'(1)) == fill_len);
    assign wr_idx      = (fill_bank ? BW'(LINE_WORDS) : '0) + BW'(rsp_cnt);
    assign fetch_busy  = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        mem_addr_vld = 1'b0;
        line_done    = 1'b0;
        swap         = 1'b0;
        set_underrun = 1'b0;
        case (state)
            IDLE: begin
                if (line_start) begin
                    swap      = 1'b1;
                    state_nxt = (len_clamped != '0) ? REQ : IDLE;
                end
            end
            REQ: begin
                mem_addr_vld = (req_cnt < fill_len) && (outstanding < OW'(MAX_OUT));
                line_done    = last_word;
                // A line_start coinciding with the final word is an on-time start.
                if (line_start) begin
                    swap = 1'b1;
                    if (last_word) begin
                        state_nxt = (len_clamped != '0) ? REQ : IDLE;
                    end else begin
                        set_underrun = 1'b1;
                        state_nxt    = DRAIN;
                    end
                end else if (last_word) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (line_start) begin
                    swap = 1'b1;
                end else if (outstanding == '0) begin
                    state_nxt = (fill_len != '0) ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fill_bank   <= 1'b0;
            fill_base   <= '0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            disp_bpp    <= '0;
            underrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_underrun) underrun <= 1'b1;
            if (addr_xfer && !dat_xfer)      outstanding <= outstanding + OW'(1);
            else if (!addr_xfer && dat_xfer) outstanding <= outstanding - OW'(1);
            if (swap) begin
                fill_bank           <= disp_bank;
                bank_len[disp_bank] <= len_clamped;
                disp_bpp            <= bpp_mode;
                fill_base           <= line_base;
                req_cnt             <= '0;
                rsp_cnt             <= '0;
            end else begin
                if (addr_xfer) req_cnt <= req_cnt + LW'(1);
                if (wr_en)     rsp_cnt <= rsp_cnt + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) line_mem[wr_idx] <= mem_dat;
    end

    // Stage p0: locate the word and bit field of the requested pixel.
    assign rd_bit_p0  = XW'(rd_col) << disp_bpp;
    assign rd_word_p0 = rd_bit_p0 / XW'(DW);
    assign rd_sh_p0   = rd_bit_p0 % XW'(DW);
    assign rd_hit_p0  = rd_word_p0 < XW'(bank_len[disp_bank]);
    assign rd_idx_p0  = rd_hit_p0 ? ((disp_bank ? BW'(LINE_WORDS) : '0) + BW'(rd_word_p0)) : '0;
    assign rd_raw_p0  = 8'(line_mem[rd_idx_p0] >> rd_sh_p0);

    // Stage p1: registered pixel, held while rd_en is low.
    always_ff @(posedge clk) begin
        if (rst)        pix_val <= '0;
        else if (rd_en) pix_val <= rd_hit_p0 ? expand_pix(rd_raw_p0, disp_bpp) : 8'h00;
    end
endmodule

// File: tb/tb_screen_line_fetch.sv
// Randomized bench for screen_line_fetch against a line-level model of the
// fetch, the ping-pong banks and the pixel unpacking arithmetic.
module tb_screen_line_fetch;
    localparam int DW = 16, AW = 19, LINE_WORDS = 64, MAX_OUT = 2;
    localparam int LW = $clog2(LINE_WORDS + 1);
    localparam int CW = $clog2(LINE_WORDS * DW);
    localparam int AMASK = (1 << AW) - 1;

    logic          clk = 0, rst = 1, line_start = 0;
    logic [AW-1:0] line_base = '0;
    logic [LW-1:0] line_len = '0;
    logic [1:0]    bpp_mode = '0;
    logic          mem_addr_vld, mem_addr_gnt = 0;
    logic [AW-1:0] mem_addr;
    logic          mem_dat_vld = 0, mem_dat_gnt;
    logic [DW-1:0] mem_dat = '0;
    logic          rd_en = 0;
    logic [CW-1:0] rd_col = '0;
    logic [7:0]    pix_val;
    logic          fetch_busy, line_done, underrun;

    screen_line_fetch #(.DW(DW), .AW(AW), .LINE_WORDS(LINE_WORDS), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_base(line_base),
        .line_len(line_len), .bpp_mode(bpp_mode), .mem_addr_vld(mem_addr_vld),
        .mem_addr_gnt(mem_addr_gnt), .mem_addr(mem_addr), .mem_dat_vld(mem_dat_vld),
        .mem_dat_gnt(mem_dat_gnt), .mem_dat(mem_dat), .rd_en(rd_en), .rd_col(rd_col),
        .pix_val(pix_val), .fetch_busy(fetch_busy), .line_done(line_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_FETCH, M_DRAIN} mph_t;

    int checks = 0, failures = 0;
    mph_t ph = M_IDLE;
    int q_addr[$];
    int q_due[$];
    int addr_log[$];
    int cur_base = 0, cur_len = 0, n_req = 0, n_rsp = 0;
    logic [DW-1:0] words [LINE_WORDS];
    logic [DW-1:0] disp_words [LINE_WORDS];
    int disp_len = 0, disp_bpp = 0;
    bit disp_valid = 1, exp_und = 0, pix_known = 1, hold = 0, rst_chk = 0;
    logic [7:0] exp_pix = 0;
    logic [AW-1:0] prev_addr = '0;
    int cyc = 0, ld_cnt = 0, q_max = 0;
    bit ls_req = 0, rst_req = 0, stall = 0, stall_rand = 0;
    int ls_base = 0, ls_len = 0, ls_bpp = 0;
    int gnt_mode = 0, lat_min = 2, lat_max = 2, rd_mode = 2, rd_col_v = 0;
    int force_addr = -1;
    logic [DW-1:0] force_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input int a);
        int unsigned h;
        if (a == force_addr) return force_val;
        h = int'(a) * 32'h9E3779B1;
        return DW'(h >> 11);
    endfunction

    function automatic int clampl(input int l);
        return (l > LINE_WORDS) ? LINE_WORDS : l;
    endfunction

    task automatic step();
        int q0, due, bpp, bitp, w;
        bit ax, dx, done, exp_vld;
        logic [DW-1:0] d, v;
        mph_t nph;
        @(negedge clk);
        cyc++;
        q0 = q_addr.size();
        if (pix_known) chk("pix_val", 32'(pix_val), 32'(exp_pix));
        chk("fetch_busy", 32'(fetch_busy), 32'(ph != M_IDLE));
        chk("underrun", 32'(underrun), 32'(exp_und));
        chk("dat_gnt", 32'(mem_dat_gnt), 32'(q0 != 0));
        exp_vld = (ph == M_FETCH) && (n_req < cur_len) && (q0 < MAX_OUT);
        chk("addr_vld", 32'(mem_addr_vld), 32'(exp_vld));
        if (exp_vld) chk("mem_addr", 32'(mem_addr), 32'((cur_base + n_req) & AMASK));
        if (hold) begin
            chk("addr_hold_vld", 32'(mem_addr_vld), 32'd1);
            chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
        end
        if (rst_chk) begin
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_pix", 32'(pix_val), 32'd0);
            rst_chk = 0;
        end
        rst = rst_req;
        if (rst_req) begin
            line_start = 0; mem_addr_gnt = 0; mem_dat_vld = 0; rd_en = 0;
            q_addr.delete(); q_due.delete();
            ph = M_IDLE; cur_base = 0; cur_len = 0; n_req = 0; n_rsp = 0;
            disp_len = 0; disp_valid = 1; exp_und = 0; exp_pix = 0; pix_known = 1;
            hold = 0; rst_req = 0; rst_chk = 1; ls_req = 0;
            return;
        end
        line_start = ls_req;
        line_base  = AW'(ls_base);
        line_len   = LW'(ls_len);
        bpp_mode   = 2'(ls_bpp);
        if (stall_rand) stall = ($urandom_range(0, 3) == 0);
        mem_addr_gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (q0 > 0 && q_due[0] <= cyc && !stall) begin
            mem_dat_vld = 1; mem_dat = mem_word(q_addr[0]);
        end else begin
            mem_dat_vld = (q0 == 0) && ($urandom_range(0, 7) == 0);
            mem_dat = DW'($urandom);
        end
        if (rd_mode == 1) begin
            rd_en = 1; rd_col = CW'(rd_col_v);
        end else if (rd_mode == 0) begin
            rd_en = 1'($urandom_range(0, 1));
            rd_col = $urandom_range(0, 1) ? CW'($urandom_range(0, (1 << CW) - 1))
                                          : CW'($urandom_range(0, 2 * LINE_WORDS));
        end else begin
            rd_en = 0;
        end
        #1;
        ax = mem_addr_vld & mem_addr_gnt;
        dx = mem_dat_vld & mem_dat_gnt;
        if (rd_en) begin
            bpp  = 1 << disp_bpp;
            bitp = int'(rd_col) * bpp;
            w    = bitp / DW;
            if (w >= disp_len) begin
                exp_pix = 0; pix_known = 1;
            end else if (!disp_valid) begin
                pix_known = 0;
            end else begin
                v = (disp_words[w] >> (bitp % DW)) & DW'((1 << bpp) - 1);
                exp_pix = 8'(int'(v) * (255 / ((1 << bpp) - 1)));
                pix_known = 1;
            end
        end
        done = 0;
        if (ax) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (q_due.size() > 0 && due < q_due[$]) due = q_due[$];
            q_addr.push_back(int'(mem_addr)); q_due.push_back(due);
            addr_log.push_back(int'(mem_addr));
            if (q_addr.size() > q_max) q_max = q_addr.size();
            n_req++;
        end
        if (dx) begin
            d = mem_word(q_addr.pop_front());
            void'(q_due.pop_front());
            if (ph == M_FETCH) begin
                words[n_rsp] = d; n_rsp++;
                done = (n_rsp == cur_len);
            end
        end
        chk("line_done", 32'(line_done), 32'(done));
        if (done) ld_cnt++;
        hold = mem_addr_vld && !mem_addr_gnt && !line_start;
        prev_addr = mem_addr;
        if (ls_req) begin
            if (ph == M_FETCH && !done) begin
                exp_und = 1; nph = M_DRAIN;
            end else if (ph == M_DRAIN) begin
                nph = M_DRAIN;
            end else begin
                nph = (clampl(ls_len) != 0) ? M_FETCH : M_IDLE;
            end
            disp_valid = (ph == M_IDLE) || done;
            disp_len = cur_len; disp_bpp = ls_bpp; disp_words = words;
            cur_base = ls_base; cur_len = clampl(ls_len); n_req = 0; n_rsp = 0;
            ph = nph;
        end else if (ph == M_FETCH && done) begin
            ph = M_IDLE;
        end else if (ph == M_DRAIN && q0 == 0) begin
            ph = (cur_len != 0) ? M_FETCH : M_IDLE;
        end
        ls_req = 0;
    endtask

    task automatic start_line(input int base, input int len, input int bpp);
        ls_req = 1; ls_base = base; ls_len = len; ls_bpp = bpp;
        step();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (ph != M_IDLE && n < limit) begin
            step(); n++;
        end
        if (ph != M_IDLE) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_col(input string tag, input int col, input logic [7:0] exp);
        rd_mode = 1; rd_col_v = col;
        step();
        rd_mode = 2;
        step();
        chk(tag, 32'(pix_val), 32'(exp));
    endtask

    task automatic show_word(input int bpp);
        start_line(32'h300, 1, 3);
        wait_idle(50);
        start_line(0, 0, bpp);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lw;
        int exp_wrap[4];
        rst_req = 1; step(); step(); step();

        // basic fetch at 8bpp, fixed 2-cycle latency
        gnt_mode = 0; lat_min = 2; lat_max = 2; rd_mode = 2;
        addr_log.delete(); ld_cnt = 0;
        start_line(32'h100, 4, 3);
        wait_idle(100);
        chk("basic_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("basic_addr_n", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("basic_addr", 32'(addr_log[i]), 32'(32'h100 + i));
        start_line(0, 0, 3);
        for (int c = 0; c < 8; c++) begin
            lw = int'(mem_word(32'h100 + c / 2));
            read_col("basic_pix", c, 8'(lw >> (8 * (c % 2))));
        end

        // address backpressure
        gnt_mode = 2; q_max = 0;
        start_line(32'h180, 6, 3);
        repeat (5) step();
        gnt_mode = 1;
        wait_idle(200);
        chk("max_out", 32'(q_max <= MAX_OUT), 32'd1);

        // address wrap
        gnt_mode = 0; addr_log.delete();
        start_line((1 << AW) - 2, 4, 3);
        wait_idle(100);
        exp_wrap = '{32'h7FFFE, 32'h7FFFF, 32'h0, 32'h1};
        chk("wrap_n", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("wrap_addr", 32'(addr_log[i]), 32'(exp_wrap[i]));

        // unpacking of 0xA5C3
        force_addr = 32'h300; force_val = 16'hA5C3;
        show_word(0);
        read_col("bpp1_c0", 0, 8'hFF);
        read_col("bpp1_c2", 2, 8'h00);
        show_word(1);
        read_col("bpp2_c1", 1, 8'h00);
        read_col("bpp2_c7", 7, 8'hAA);
        show_word(2);
        read_col("bpp4_c3", 3, 8'hAA);
        read_col("bpp4_c0", 0, 8'h33);
        show_word(3);
        read_col("bpp8_c1", 1, 8'hA5);
        read_col("past_len", 16, 8'h00);
        force_addr = -1;

        // underrun with a second line_start during drain
        lat_min = 3; lat_max = 3; stall = 0;
        start_line(32'h400, 8, 3);
        for (int n = 0; n < 100 && n_rsp < 3; n++) step();
        stall = 1;
        step(); step();
        start_line(32'h500, 5, 3);
        step();
        chk("und_set", 32'(underrun), 32'd1);
        chk("und_busy", 32'(fetch_busy), 32'd1);
        step(); step();
        addr_log.delete();
        start_line(32'h600, 3, 2);
        chk("drain_kept", 32'(ph == M_DRAIN), 32'd1);
        repeat (3) step();
        stall = 0;
        wait_idle(200);
        chk("drain_n", 32'(addr_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < addr_log.size(); i++)
            chk("drain_addr", 32'(addr_log[i]), 32'(32'h600 + i));
        start_line(0, 0, 2);
        rd_mode = 0;
        repeat (20) step();
        rd_mode = 2;
        chk("und_sticky", 32'(underrun), 32'd1);

        // reset with two requests outstanding
        stall = 1;
        start_line(32'h700, 8, 3);
        for (int n = 0; n < 50 && q_addr.size() < 2; n++) step();
        rst_req = 1; step(); step();
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_und", 32'(underrun), 32'd0);
        chk("rst_vld", 32'(mem_addr_vld), 32'd0);
        chk("rst_done", 32'(line_done), 32'd0);
        stall = 0; addr_log.delete();
        start_line(32'h800, 0, 3);
        repeat (5) step();
        chk("len0_no_req", 32'(addr_log.size()), 32'd0);

        // randomized lines with random grants, latency and stalls
        gnt_mode = 1; lat_min = 1; lat_max = 4; stall_rand = 1; rd_mode = 0;
        for (int l = 0; l < 40; l++) begin
            start_line(int'($urandom_range(0, AMASK)), int'($urandom_range(0, 80)),
                       int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 120)) step();
            if (ph == M_FETCH && n_rsp + 2 > cur_len) wait_idle(400);
        end
        stall_rand = 0; stall = 0;
        wait_idle(400);
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
